rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
// PURPOSE
//  Round-robin arbiter that shares one resource among N_REQ requesters.
//  A rotating priority encoder (scan from high index downward, wrapping) picks one requester.
//  The grant is held until the owner drops its request, or until a hold timeout forces a handover.
//  Sits in front of any shared datapath (bus, ALU, memory port); grant_id drives that datapath's select mux.
// PARAMETERS
//  N_REQ     8   number of requesters; power of 2, 2..8
//  MAX_HOLD  16  max consecutive grant cycles before forced handover; 0 = no timeout
// PORTS
//  clk          in   1                clock, all state on rising edge
//  reset        in   1                asynchronous, active-high; clears all state immediately
//  req          in   N_REQ            request vector, one bit per requester, level-sensitive
//  grant        out  N_REQ            one-hot grant, all zero when idle
//  grant_id     out  $clog2(N_REQ)    binary index of the grant holder; 0 when idle
//  grant_valid  out  1                1 while any grant is active (== |grant)
//  preempt      out  1                1-cycle pulse on the edge a timeout forces a handover
// BEHAVIOUR
//  Reset values: grant=0, grant_id=0, grant_valid=0, preempt=0, state=IDLE, hold_cnt=0, last_id=0.
//  Search order from last_id L: L-1, L-2, ..., 0, N_REQ-1, ..., L (mod N_REQ); first req bit set wins.
//   After reset L=0, so search starts at N_REQ-1 (the highest index wins, as in a plain priority encoder).
//  All outputs are registered. Decisions use req sampled at the rising edge; the new grant is visible
//   after that edge (1-cycle latency from req to grant).
//  States:
//   IDLE:  if |req, go to GRANT with the winner; load grant/grant_id; set last_id=winner; hold_cnt=0.
//          Otherwise stay in IDLE.
//   GRANT: release: if req[grant_id]==0, re-arbitrate on the same edge, excluding the holder.
//            A winner exists -> switch directly, with no idle cycle. No winner -> go to IDLE (grant=0).
//          timeout: if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and req[grant_id]==1:
//            another req bit set -> switch to the winner (holder excluded from the search);
//              preempt=1 for that one cycle.
//            no other req -> keep the holder; hold_cnt=0; preempt stays 0.
//          otherwise: hold the grant and increment hold_cnt.
//  hold_cnt width is $clog2(MAX_HOLD+1). It resets to 0 on every new or renewed grant and never wraps.
//  last_id updates only when the grant changes owner, so a renewed sole holder does not move the pointer.
//  Simultaneous release and other requests on one edge: release wins, and normal handover happens (no preempt).
//  Requests that rise and fall between edges are ignored. A requester whose req drops and rises again
//   while another owner holds the grant waits its turn.
//  Asserting reset mid-grant drops grant, grant_valid and preempt asynchronously. After reset is released,
//   the first arbitration restarts from index N_REQ-1.
//  Invariant: grant is one-hot or zero, and grant == (grant_valid << grant_id).
// TESTING (defaults N_REQ=8; MAX_HOLD as stated per test)
//  1. reset=1 -> all outputs 0. Release reset; req=8'h81 -> after 1 edge grant=8'h80, grant_id=7, grant_valid=1.
//  2. Continue test 1; drop req[7] (req=8'h01) -> next edge grant=8'h01, grant_id=0, no idle cycle, preempt=0.
//  3. MAX_HOLD=4, req=8'hFF held -> owners 7,6,5,...,0,7, each for 4 cycles; preempt pulses once per handover.
//  4. MAX_HOLD=4, req=8'h04 held for 20 cycles -> grant stays 8'h04, preempt never 1, hold_cnt restarts every 4 cycles.
//  5. Owner 3 granted; pulse reset mid-grant -> grant=0 with no clock edge. Release reset; req=8'hFF -> grant_id=7.
//  6. MAX_HOLD=0, req=8'h30 held for 100 cycles -> grant stays on 5. Drop req[5] -> grant moves to 4.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with hold-until-release grants and an optional
// hold timeout that forces a handover to the next waiting requester.
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_valid,
  output logic                     preempt
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic            preempt_q, preempt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]   last_id_q, last_id_d;

  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_all, win_ex;
  logic            any_all, any_ex;
  logic            timeout;

  // Scan last-1 downward with wrap; offset N_REQ lands back on last_id,
  // which is the holder while granted, so win_ex skips it.
  always_comb begin
    cand    = '0;
    win_all = '0;
    win_ex  = '0;
    any_all = 1'b0;
    any_ex  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_id_q - IW'(k);
      if (req[cand] && !any_all) begin
        any_all = 1'b1;
        win_all = cand;
      end
      if (k < N_REQ && req[cand] && !any_ex) begin
        any_ex = 1'b1;
        win_ex = cand;
      end
    end
  end

  assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    last_id_d     = last_id_q;
    unique case (state_q)
      IDLE: begin
        if (any_all) begin
          state_d       = GRANT;
          grant_id_d    = win_all;
          grant_valid_d = 1'b1;
          last_id_d     = win_all;
          hold_cnt_d    = '0;
        end
      end
      GRANT: begin
        if (!req[grant_id_q]) begin
          if (any_ex) begin
            grant_id_d = win_ex;
            last_id_d  = win_ex;
            hold_cnt_d = '0;
          end else begin
            state_d       = IDLE;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
          end
        end else if (timeout) begin
          hold_cnt_d = '0;
          if (any_ex) begin
            grant_id_d = win_ex;
            last_id_d  = win_ex;
            preempt_d  = 1'b1;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = N_REQ'(grant_valid_d) << grant_id_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
      hold_cnt_q    <= '0;
      last_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
      hold_cnt_q    <= hold_cnt_d;
      last_id_q     <= last_id_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: three instances (MAX_HOLD 16/4/0)
// driven by the same req/reset and checked against a tenure-based model.
module tb_rr_grant_arbiter;

  localparam int N = 8;
  localparam int ND = 3;

  typedef logic [ND-1:0][12:0] exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   g [ND];
  logic [2:0]     gid [ND];
  logic           gv [ND];
  logic           pre [ND];

  int mh [ND] = '{16, 4, 0};
  int owner [ND];
  int last [ND];
  int ten [ND];

  exp_t sb [$];
  int n_chk = 0;
  int n_fail = 0;
  bit in_rst = 1'b1;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(16)) u_mh16 (
    .clk(clk), .reset(reset), .req(req), .grant(g[0]),
    .grant_id(gid[0]), .grant_valid(gv[0]), .preempt(pre[0]));
  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(4)) u_mh4 (
    .clk(clk), .reset(reset), .req(req), .grant(g[1]),
    .grant_id(gid[1]), .grant_valid(gv[1]), .preempt(pre[1]));
  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(0)) u_mh0 (
    .clk(clk), .reset(reset), .req(req), .grant(g[2]),
    .grant_id(gid[2]), .grant_valid(gv[2]), .preempt(pre[2]));

  function automatic int pick(logic [N-1:0] r, int l, int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = ((l - k) % N + N) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [12:0] obs(int d);
    return {g[d], gid[d], gv[d], pre[d]};
  endfunction

  task automatic model_step(input logic [N-1:0] r, input bit rst,
                            output exp_t e);
    for (int d = 0; d < ND; d++) begin
      bit p;
      int w;
      logic [7:0] eg;
      logic [2:0] eid;
      p = 1'b0;
      if (rst) begin
        owner[d] = -1; last[d] = 0; ten[d] = 0;
      end else if (owner[d] < 0) begin
        w = pick(r, last[d], -1);
        if (w >= 0) begin
          owner[d] = w; last[d] = w; ten[d] = 1;
        end
      end else if (!r[owner[d]]) begin
        w = pick(r, last[d], owner[d]);
        if (w >= 0) begin
          owner[d] = w; last[d] = w; ten[d] = 1;
        end else begin
          owner[d] = -1; ten[d] = 0;
        end
      end else if (mh[d] != 0 && ten[d] == mh[d]) begin
        w = pick(r, last[d], owner[d]);
        ten[d] = 1;
        if (w >= 0) begin
          owner[d] = w; last[d] = w; p = 1'b1;
        end
      end else begin
        ten[d]++;
      end
      eg  = (owner[d] >= 0) ? 8'(1 << owner[d]) : 8'h00;
      eid = (owner[d] >= 0) ? 3'(owner[d]) : 3'd0;
      e[d] = {eg, eid, owner[d] >= 0, p};
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int d = 0; d < ND; d++) begin
      n_chk++;
      if (obs(d) != 13'd0) begin
        n_fail++;
        $display("FAIL %s dut%0d: got %h want 0000", nm, d, obs(d));
      end
    end
  endtask

  // One cycle of stimulus, issued at the falling edge.
  task automatic step(input logic [N-1:0] r, input bit rst,
                      input logic [N-1:0] glitch);
    exp_t e;
    @(negedge clk);
    req = r;
    reset = rst;
    model_step(r, rst, e);
    sb.push_back(e);
    if (rst && !in_rst) begin
      #1;
      chk_zero("async_reset");
    end else if (!rst && glitch != '0) begin
      #1 req = r ^ glitch;
      #2 req = r;
    end
    in_rst = rst;
  endtask

  task automatic run(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int d = 0; d < ND; d++) begin
          n_chk++;
          if (obs(d) != e[d]) begin
            n_fail++;
            $display("FAIL cycle_out dut%0d t=%0t: got g=%h id=%0d v=%0b p=%0b want g=%h id=%0d v=%0b p=%0b",
                     d, $time, g[d], gid[d], gv[d], pre[d],
                     e[d][12:5], e[d][4:2], e[d][1], e[d][0]);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [N-1:0] r;
    for (int d = 0; d < ND; d++) begin
      owner[d] = -1; last[d] = 0; ten[d] = 0;
    end
    #1;
    chk_zero("reset_state");
    step('0, 1'b1, '0);
    step('0, 1'b1, '0);
    run(8'h81, 2);
    run(8'h01, 3);
    step('0, 1'b1, '0);
    run(8'hFF, 40);
    run(8'h04, 20);
    step('0, 1'b1, '0);
    run(8'h08, 3);
    step(8'h08, 1'b1, '0);
    step(8'h08, 1'b1, '0);
    run(8'hFF, 3);
    run(8'h30, 100);
    run(8'h10, 3);
    run(8'h00, 2);
    run(8'h20, 2);
    step(8'h20, 1'b0, 8'h80);
    step(8'h21, 1'b0, 8'h40);
    run(8'h01, 2);
    r = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] gl;
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 20) r[$urandom_range(0, N - 1)] ^= 1'b1;
      else if (sel < 25) r = 8'($urandom);
      gl = (sel >= 90) ? 8'($urandom) : 8'h00;
      if (sel == 50) step(r, 1'b1, '0);
      else step(r, 1'b0, gl);
    end
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
